rr_burst_sel_arbiter: RTL and testbench
=======================================

Name: rr_burst_sel_arbiter

Overview:
- Round-robin arbiter upstream of the 4:1 registered data mux.
- Chooses one of four requesting sources and drives the mux `sel` from a register.
- Holds the grant for a burst of up to BURST_LEN beats.
- Emits `out_valid`, aligned with the one-cycle-registered mux output, so downstream logic knows which output words are real data.

Parameters:
- BURST_LEN, 4: maximum beats per grant, minimum 1.
- CNT_W, 3: beat counter width, at least clog2(BURST_LEN)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  per-source request, level; req[i] high means source i has a word on mux input i.
- en  input  1  downstream advance; when low, the arbiter freezes.
- sel  output  2  registered select to the data mux.
- grant  output  4  registered one-hot grant, equal to 1<<sel when busy, 0 when idle.
- busy  output  1  registered; high while a grant is held.
- beat  output  1  combinational: busy & req[sel] & en. Source sel's word is consumed this cycle; sources pop on beat & grant[i].
- out_valid  output  1  registered beat, delayed 1 cycle; qualifies the mux's registered output.
- burst_last  output  1  combinational: beat & (cnt==0).

Behaviour:
- Reset (rst low, async):
  - sel=0, grant=0, busy=0, out_valid=0, cnt=0.
  - Priority pointer last=3, so source 0 has first priority after reset.
- State: IDLE (busy=0) or BURST (busy=1), plus cnt and last.
- en=0 at an edge:
  - sel, grant, busy, cnt and last hold.
  - out_valid loads 0.
  - Requests are not sampled for arbitration.
- Arbitrate (all with en=1 at the edge) in three cases:
  - state is IDLE;
  - state is BURST and beat & cnt==0 (last beat);
  - state is BURST and req[sel]==0 (source withdrew, no beat).
- Winner rule:
  - Winner = first i with req[i]=1, scanning last+1, last+2, last+3, last+4, all mod 4.
  - The current holder is therefore lowest priority.
- Winner exists:
  - sel<=winner, grant<=1<<winner, busy<=1, cnt<=BURST_LEN-1, last<=winner.
  - No idle bubble between back-to-back bursts.
- No winner:
  - busy<=0, grant<=0, cnt<=0.
  - sel holds its last value; last holds.
- BURST, beat and cnt!=0: cnt<=cnt-1, grant holds.
- Latency:
  - req sampled at edge N gives grant/sel valid in cycle N+1.
  - First beat can occur in cycle N+1.
  - out_valid for that beat is high in cycle N+2, the same cycle the mux register presents the data.
- out_valid <= beat at every enabled edge. Every beat produces exactly one out_valid pulse.
- BURST_LEN=1: every beat is the last beat, so the grant rotates every beat.
- Simultaneous last beat and new requests: next winner is selected at the same edge; the prior holder has lowest priority.
- Reset mid-burst: state is cleared immediately. No out_valid follows the asserted reset, including for a beat in the reset cycle.
- Widths: cnt wraps are unreachable by construction. The cnt-1 decrement never executes when cnt==0.

Test Plan:
- Reset, then req=4'b0100, en=1 held:
  - sel=2 and grant=4'b0100 one cycle after the first sampled edge.
  - Exactly 4 beats.
  - Re-grant to source 2 with no bubble, since it is the only requester.
  - out_valid lags beat by exactly 1 cycle.
- req=4'b1111 constant, BURST_LEN=4: grant sequence 0,1,2,3,0, each for 4 consecutive beats, no gap cycles; burst_last on every 4th beat.
- Source 1 granted, req[1] dropped after 2 beats while req[3]=1: the next edge grants 3 with cnt reloaded to 3; 2 out_valid pulses attributed to source 1.
- en low for 3 cycles mid-burst, cnt=2:
  - sel, grant and cnt frozen; beat=0.
  - out_valid low from the next cycle.
  - Burst resumes with 3 beats remaining after en returns high.
- rst asserted asynchronously between edges during a burst: grant, busy, sel and out_valid go 0 immediately; after release with req=4'b1111, source 0 wins first.
- req=0 after a burst on source 2: busy=0, grant=0, sel stays 2; a later req=4'b0101 grants source 0, next after last=2 in priority order 3,0,1,2.

Source files
------------

// File: rtl/rr_burst_sel_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_burst_sel_arbiter_if
//   Handshake bundle between the round-robin burst arbiter and the request
//   sources / 4:1 registered data mux it steers.
//
//   req        : per-source request level (source i has a word on mux input i)
//   en         : downstream advance; low freezes the arbiter
//   sel        : registered mux select
//   grant      : registered one-hot grant (0 when idle)
//   busy       : registered, high while a grant is held
//   beat       : combinational, word of source sel consumed this cycle
//   out_valid  : beat delayed one cycle, qualifies the registered mux output
//   burst_last : combinational, beat is the final beat of the burst
//
//   master : arbiter side
//   slave  : source / mux side
// ---------------------------------------------------------------------------
interface rr_burst_sel_arbiter_if;

   logic [3:0] req;
   logic       en;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
   logic       beat;
   logic       out_valid;
   logic       burst_last;

   modport master (
      input  req,
      input  en,
      output sel,
      output grant,
      output busy,
      output beat,
      output out_valid,
      output burst_last
   );

   modport slave (
      output req,
      output en,
      input  sel,
      input  grant,
      input  busy,
      input  beat,
      input  out_valid,
      input  burst_last
   );

endinterface

// File: rtl/rr_burst_sel_arbiter.sv
// ---------------------------------------------------------------------------
// rr_burst_sel_arbiter
//   Round-robin arbiter in front of a 4:1 registered data mux. Picks one of
//   four requesting sources, drives the mux select from a register and holds
//   the grant for a burst of up to BURST_LEN beats. out_valid is the beat
//   strobe delayed one cycle so it lines up with the registered mux output.
//
//   Parameters
//     BURST_LEN : maximum beats per grant (>= 1)
//     CNT_W     : beat counter width (>= clog2(BURST_LEN)+1)
//
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous, active-low reset
//     bus : rr_burst_sel_arbiter_if.master (req, en in; sel, grant, busy,
//           beat, out_valid, burst_last out)
// ---------------------------------------------------------------------------
module rr_burst_sel_arbiter #(
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   rr_burst_sel_arbiter_if.master bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state_q;
   logic [1:0]         sel_q;
   logic [1:0]         last_q;
   logic [3:0]         grant_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               out_valid_q;

   logic               busy;
   logic               beat;
   logic               cnt_zero;
   logic               arbitrate;
   logic               win_found;
   logic [1:0]         win_idx;
   logic [1:0]         cand;

   assign busy      = (state_q == BURST);
   assign cnt_zero  = (cnt_q == '0);
   assign beat      = busy & bus.req[sel_q] & bus.en;

   // Re-arbitrate when idle, on the last beat of a burst, or when the
   // holder withdrew its request (no beat this cycle).
   assign arbitrate = (state_q == IDLE)
                    | (beat & cnt_zero)
                    | (busy & ~bus.req[sel_q]);

   // Scan last+1 .. last+4 (mod 4); the previous winner is checked last,
   // which gives it the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      cand      = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         last_q      <= 2'd3;
         grant_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.en) begin
         out_valid_q <= beat;
         if (arbitrate) begin
            if (win_found) begin
               state_q <= BURST;
               sel_q   <= win_idx;
               grant_q <= 4'(1) << win_idx;
               cnt_q   <= CNT_W'(BURST_LEN - 1);
               last_q  <= win_idx;
            end else begin
               // sel and last keep their values so the pointer survives idle
               state_q <= IDLE;
               grant_q <= '0;
               cnt_q   <= '0;
            end
         end else if (beat) begin
            // arbitrate covers beat & cnt==0, so cnt is nonzero here
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.grant      = grant_q;
   assign bus.busy       = busy;
   assign bus.beat       = beat;
   assign bus.out_valid  = out_valid_q;
   assign bus.burst_last = beat & cnt_zero;

endmodule

// File: tb/tb_rr_burst_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_burst_sel_arbiter
//   Directed bench for rr_burst_sel_arbiter (BURST_LEN=4, CNT_W=3).
//   Inputs change on the falling edge; outputs are checked 1 time unit
//   later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_rr_burst_sel_arbiter;

   logic clk;
   logic rst;

   int unsigned n_checks;
   int unsigned n_fail;

   rr_burst_sel_arbiter_if bus ();

   rr_burst_sel_arbiter #(
      .BURST_LEN (4),
      .CNT_W     (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reset asserted on a falling edge, released on the next one.
   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      bus.req = 4'b0000;
      bus.en  = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [1:0] e;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      bus.req  = 4'b0000;
      bus.en   = 1'b0;

      // ---- reset state ----
      #2;
      check("reset_sel",   32'(bus.sel),        32'd0);
      check("reset_grant", 32'(bus.grant),      32'd0);
      check("reset_busy",  32'(bus.busy),       32'd0);
      check("reset_ov",    32'(bus.out_valid),  32'd0);
      check("reset_beat",  32'(bus.beat),       32'd0);
      check("reset_last",  32'(bus.burst_last), 32'd0);

      // ---- single requester 2: 4-beat bursts, re-grant with no bubble ----
      @(negedge clk);
      rst     = 1'b1;
      bus.req = 4'b0100;
      bus.en  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         check("t1_sel",   32'(bus.sel),        32'd2);
         check("t1_grant", 32'(bus.grant),      32'h4);
         check("t1_beat",  32'(bus.beat),       32'd1);
         check("t1_last",  32'(bus.burst_last), 32'((k % 4) == 3));
         check("t1_ov",    32'(bus.out_valid),  32'(k != 0));
      end

      // ---- all requesting: rotation 0,1,2,3,0 in 4-beat bursts ----
      do_reset();
      bus.req = 4'b1111;
      bus.en  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         e = 2'((k / 4) % 4);
         check("t2_sel",   32'(bus.sel),        32'(e));
         check("t2_grant", 32'(bus.grant),      32'(4'(1) << e));
         check("t2_beat",  32'(bus.beat),       32'd1);
         check("t2_last",  32'(bus.burst_last), 32'((k % 4) == 3));
         check("t2_ov",    32'(bus.out_valid),  32'(k != 0));
      end

      // ---- source 1 withdraws after 2 beats, source 3 takes over ----
      do_reset();
      bus.req = 4'b1010;
      bus.en  = 1'b1;
      @(negedge clk);
      #1;
      check("t3_sel1",  32'(bus.sel),       32'd1);
      check("t3_beat1", 32'(bus.beat),      32'd1);
      check("t3_ov1",   32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("t3_beat2", 32'(bus.beat),      32'd1);
      check("t3_ov2",   32'(bus.out_valid), 32'd1);
      @(negedge clk);
      bus.req = 4'b1000;
      #1;
      check("t3_wd_beat", 32'(bus.beat),      32'd0);
      check("t3_wd_busy", 32'(bus.busy),      32'd1);
      check("t3_wd_sel",  32'(bus.sel),       32'd1);
      check("t3_wd_ov",   32'(bus.out_valid), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("t3_sel3",  32'(bus.sel),        32'd3);
         check("t3_grant", 32'(bus.grant),      32'h8);
         check("t3_beat",  32'(bus.beat),       32'd1);
         check("t3_last",  32'(bus.burst_last), 32'(k == 3));
         check("t3_ov",    32'(bus.out_valid),  32'(k != 0));
      end

      // ---- en low for 3 cycles with cnt=2 ----
      do_reset();
      bus.req = 4'b0001;
      bus.en  = 1'b1;
      @(negedge clk);
      #1;
      check("t4_beat0", 32'(bus.beat), 32'd1);
      @(negedge clk);
      bus.en = 1'b0;
      #1;
      check("t4_hold_beat",  32'(bus.beat),       32'd0);
      check("t4_hold_grant", 32'(bus.grant),      32'h1);
      check("t4_hold_ov",    32'(bus.out_valid),  32'd1);
      check("t4_hold_last",  32'(bus.burst_last), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check("t4_frz_ov",    32'(bus.out_valid), 32'd0);
         check("t4_frz_beat",  32'(bus.beat),      32'd0);
         check("t4_frz_grant", 32'(bus.grant),     32'h1);
         check("t4_frz_busy",  32'(bus.busy),      32'd1);
         check("t4_frz_sel",   32'(bus.sel),       32'd0);
      end
      @(negedge clk);
      bus.en = 1'b1;
      #1;
      check("t4_res_beat",  32'(bus.beat),       32'd1);
      check("t4_res_ov",    32'(bus.out_valid),  32'd0);
      check("t4_res_last",  32'(bus.burst_last), 32'd0);
      check("t4_res_grant", 32'(bus.grant),      32'h1);
      @(negedge clk);
      #1;
      check("t4_b2_beat", 32'(bus.beat),       32'd1);
      check("t4_b2_last", 32'(bus.burst_last), 32'd0);
      check("t4_b2_ov",   32'(bus.out_valid),  32'd1);
      @(negedge clk);
      #1;
      check("t4_b3_beat", 32'(bus.beat),       32'd1);
      check("t4_b3_last", 32'(bus.burst_last), 32'd1);

      // ---- asynchronous reset mid-burst ----
      do_reset();
      bus.req = 4'b0010;
      bus.en  = 1'b1;
      @(negedge clk);
      #1;
      check("t5_sel1", 32'(bus.sel), 32'd1);
      @(negedge clk);
      #1;
      check("t5_busy", 32'(bus.busy),      32'd1);
      check("t5_ov",   32'(bus.out_valid), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("t5_ar_grant", 32'(bus.grant),     32'd0);
      check("t5_ar_busy",  32'(bus.busy),      32'd0);
      check("t5_ar_sel",   32'(bus.sel),       32'd0);
      check("t5_ar_ov",    32'(bus.out_valid), 32'd0);
      check("t5_ar_beat",  32'(bus.beat),      32'd0);
      @(negedge clk);
      rst     = 1'b1;
      bus.req = 4'b1111;
      @(negedge clk);
      #1;
      check("t5_rel_sel",   32'(bus.sel),       32'd0);
      check("t5_rel_grant", 32'(bus.grant),     32'h1);
      check("t5_rel_ov",    32'(bus.out_valid), 32'd0);

      // ---- go idle after source 2, then 0101 grants source 0 ----
      do_reset();
      bus.req = 4'b0100;
      bus.en  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check("t6_grant", 32'(bus.grant), 32'h4);
      end
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      check("t6_wd_beat", 32'(bus.beat), 32'd0);
      check("t6_wd_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      #1;
      check("t6_idle_busy",  32'(bus.busy),      32'd0);
      check("t6_idle_grant", 32'(bus.grant),     32'd0);
      check("t6_idle_sel",   32'(bus.sel),       32'd2);
      check("t6_idle_ov",    32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("t6_idle2_sel",  32'(bus.sel),       32'd2);
      check("t6_idle2_ov",   32'(bus.out_valid), 32'd0);
      bus.req = 4'b0101;
      @(negedge clk);
      #1;
      check("t6_new_sel",   32'(bus.sel),   32'd0);
      check("t6_new_grant", 32'(bus.grant), 32'h1);
      check("t6_new_busy",  32'(bus.busy),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
